mul_byte_sequencer: RTL

//  Byte-serial front/back end for the 8x8 multiplier interface stage.
//  - Collects operand A, then operand B, from an 8-bit valid/ready input stream.
//  - Drives mul_ip_BA and a one-cycle mul_start pulse to the multiplier interface.
//  - Captures the 16-bit product once mul_ready completes its low-then-high cycle.
//  - Returns the product as two bytes on an 8-bit valid/ready output stream.

---
 rtl/mul_byte_sequencer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mul_byte_sequencer.sv
// Byte-serial sequencer around the 8x8 multiplier interface stage.
// Collects operand A then B from an 8-bit stream, launches the multiplier,
// waits for its ready low-then-high handshake, captures the 16-bit product
// and returns it as two bytes on an 8-bit output stream.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_A    | idle, accepting operand A
// S_B    | accepting operand B
// S_GO   | mul_start high for this single cycle, ack counter cleared
// S_ACK  | waiting for mul_ready to drop (bounded by TIMEOUT_CYC)
// S_DONE | waiting for mul_ready to return high, then capture product
// S_O1   | presenting first product byte
// S_O2   | presenting second product byte
module mul_byte_sequencer #(
    parameter int TIMEOUT_CYC   = 7,
    parameter bit OUT_LSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] mul_ip_BA,
    output logic        mul_start,
    input  logic [15:0] mul_op_prod,
    input  logic        mul_ready,
    output logic        busy,
    output logic        timeout_err,
    output logic [7:0]  op_count
);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_GO   = 3'd2,
        S_ACK  = 3'd3,
        S_DONE = 3'd4,
        S_O1   = 3'd5,
        S_O2   = 3'd6
    } state_t;

    // Last counter value tolerated in S_ACK with mul_ready still high.
    localparam logic [3:0] ACK_LAST = 4'(TIMEOUT_CYC - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  ack_cnt;
    logic [15:0] prod_reg;
    logic        in_acc;
    logic        out_acc;
    logic        ack_to;

    // Handshake decodes; stream flags come straight from the state so reset
    // drops them immediately.
    always_comb begin
        in_ready  = (state == S_A) || (state == S_B);
        out_valid = (state == S_O1) || (state == S_O2);
        busy      = (state != S_A);
        in_acc    = in_valid && in_ready;
        out_acc   = out_valid && out_ready;
        ack_to    = (state == S_ACK) && mul_ready && (ack_cnt == ACK_LAST);
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_A:     if (in_acc) state_nxt = S_B;
            S_B:     if (in_acc) state_nxt = S_GO;
            S_GO:    state_nxt = S_ACK;
            S_ACK:   if (!mul_ready || ack_to) state_nxt = S_DONE;
            S_DONE:  if (mul_ready) state_nxt = S_O1;
            S_O1:    if (out_acc) state_nxt = S_O2;
            S_O2:    if (out_acc) state_nxt = S_A;
            default: state_nxt = S_A;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_A;
        else        state <= state_nxt;
    end

    // Operand capture and the registered start pulse, which is raised on the
    // edge entering S_GO so it is high exactly while the FSM sits there.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mul_ip_BA <= 16'h0000;
            mul_start <= 1'b0;
        end else begin
            mul_start <= (state == S_B) && in_acc;
            if (in_acc && (state == S_A)) mul_ip_BA[7:0]  <= in_data;
            if (in_acc && (state == S_B)) mul_ip_BA[15:8] <= in_data;
        end
    end

    // Ack wait counter and sticky timeout flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_cnt     <= 4'd0;
            timeout_err <= 1'b0;
        end else begin
            if (state == S_GO)
                ack_cnt <= 4'd0;
            else if ((state == S_ACK) && mul_ready && !ack_to)
                ack_cnt <= ack_cnt + 4'd1;
            if (ack_to) timeout_err <= 1'b1;
        end
    end

    // Product capture and completed-operation count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prod_reg <= 16'h0000;
            op_count <= 8'h00;
        end else begin
            if ((state == S_DONE) && mul_ready) prod_reg <= mul_op_prod;
            if ((state == S_O2) && out_acc)     op_count <= op_count + 8'h01;
        end
    end

    // Output byte select; only driven from the freshly captured product.
    always_comb begin
        out_data = 8'h00;
        if (state == S_O1)
            out_data = OUT_LSB_FIRST ? prod_reg[7:0] : prod_reg[15:8];
        else if (state == S_O2)
            out_data = OUT_LSB_FIRST ? prod_reg[15:8] : prod_reg[7:0];
    end

endmodule
